// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
//   Shared types and constants for the counter sequencer: the sequencer FSM
//   state encoding, the configuration register address map and the encoding
//   of an infinite repeat count.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_e;

  // Configuration address map (START and END occupy NSEG consecutive slots)
  localparam int ADDR_START0  = 0;
  localparam int ADDR_END0    = 4;
  localparam int ADDR_LASTSEG = 8;
  localparam int ADDR_REPEAT  = 9;

  // A REPEAT value of zero means the segment list loops forever
  localparam int REPEAT_INFINITE = 0;

endpackage

// File: rtl/counter_seq_cfg_regs.sv
// counter_seq_cfg_regs
//   Register file holding the segment list (START/END per segment), the index
//   of the last active segment and the repeat count. Writes are applied only
//   when wr_en is high; the caller folds ena and the IDLE lockout into wr_en.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        qualified write strobe
//   addr, wdata  write address / data
//   start_val    START value of every segment
//   end_val      END value of every segment
//   last_seg     index of the last segment, clamped to NSEG-1
//   repeat_val   number of passes through the list (0 = forever)
module counter_seq_cfg_regs
  import counter_seq_pkg::*;
#(
  parameter int NSEG   = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [CNT_W-1:0]           wdata,
  output logic [NSEG-1:0][CNT_W-1:0] start_val,
  output logic [NSEG-1:0][CNT_W-1:0] end_val,
  output logic [1:0]                 last_seg,
  output logic [CNT_W-1:0]           repeat_val
);

  localparam int         SEG_W   = $clog2(NSEG);
  localparam logic [1:0] SEG_MAX = 2'(NSEG - 1);

  logic [NSEG-1:0][CNT_W-1:0] start_q, start_d;
  logic [NSEG-1:0][CNT_W-1:0] end_q, end_d;
  logic [1:0]                 last_seg_q, last_seg_d;
  logic [CNT_W-1:0]           repeat_q, repeat_d;

  logic [ADDR_W-1:0] start_off;
  logic [ADDR_W-1:0] end_off;
  logic [1:0]        ls_req;

  // Offsets into the START and END banks; an offset >= NSEG is outside the bank
  assign start_off = addr - ADDR_W'(ADDR_START0);
  assign end_off   = addr - ADDR_W'(ADDR_END0);
  assign ls_req    = wdata[1:0];

  always_comb begin
    start_d    = start_q;
    end_d      = end_q;
    last_seg_d = last_seg_q;
    repeat_d   = repeat_q;
    if (wr_en) begin
      if (start_off < ADDR_W'(NSEG)) begin
        start_d[start_off[SEG_W-1:0]] = wdata;
      end else if (end_off < ADDR_W'(NSEG)) begin
        end_d[end_off[SEG_W-1:0]] = wdata;
      end else if (addr == ADDR_W'(ADDR_LASTSEG)) begin
        last_seg_d = (ls_req > SEG_MAX) ? SEG_MAX : ls_req;
      end else if (addr == ADDR_W'(ADDR_REPEAT)) begin
        repeat_d = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= '0;
      end_q      <= '0;
      last_seg_q <= '0;
      repeat_q   <= CNT_W'(1);
    end else begin
      start_q    <= start_d;
      end_q      <= end_d;
      last_seg_q <= last_seg_d;
      repeat_q   <= repeat_d;
    end
  end

  assign start_val  = start_q;
  assign end_val    = end_q;
  assign last_seg   = last_seg_q;
  assign repeat_val = repeat_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Walks an external loadable up-counter through a list of count segments.
//   Each segment loads START, lets the counter run until it reads back END,
//   then moves to the next segment; the list is repeated REPEAT times
//   (forever when REPEAT is 0). A one-cycle done pulse marks normal completion.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               low freezes the sequencer and blocks all strobes
//   cfg_we/addr/wdata configuration write port (accepted only while idle)
//   start             launches the sequence when idle
//   abort             returns to idle immediately from any active state
//   cnt_value         counter feedback
//   cnt_load          counter load strobe, cnt_load_value its data
//   cnt_en            counter increment enable
//   cnt_oe            counter output enable
//   busy              segment list in progress
//   seg_idx           current segment index
//   done              one-cycle completion pulse
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int NSEG   = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cnt_value,
  output logic              cnt_load,
  output logic [CNT_W-1:0]  cnt_load_value,
  output logic              cnt_en,
  output logic              cnt_oe,
  output logic              busy,
  output logic [1:0]        seg_idx,
  output logic              done
);

  localparam int SEG_W = $clog2(NSEG);

  logic [NSEG-1:0][CNT_W-1:0] start_val;
  logic [NSEG-1:0][CNT_W-1:0] end_val;
  logic [1:0]                 last_seg;
  logic [CNT_W-1:0]           repeat_val;

  state_e           state_q, state_d;
  logic [1:0]       seg_q, seg_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic cfg_wr;
  logic at_end;

  // Configuration is locked while a sequence is active
  assign cfg_wr = cfg_we & ena & (state_q == IDLE);

  counter_seq_cfg_regs #(
    .NSEG   (NSEG),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_cfg_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (cfg_wr),
    .addr       (cfg_addr),
    .wdata      (cfg_wdata),
    .start_val  (start_val),
    .end_val    (end_val),
    .last_seg   (last_seg),
    .repeat_val (repeat_val)
  );

  assign at_end = (cnt_value == end_val[seg_q[SEG_W-1:0]]);

  always_comb begin
    state_d        = state_q;
    seg_d          = seg_q;
    remaining_d    = remaining_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_en         = 1'b0;
    done           = 1'b0;
    // Purely state-derived, so they hold naturally while ena is low
    cnt_oe         = (state_q == RUN) || (state_q == NEXT) || (state_q == DONE);
    busy           = (state_q == LOAD) || (state_q == RUN) || (state_q == NEXT);

    if (ena) begin
      if (abort && (state_q != IDLE)) begin
        state_d = IDLE;
        seg_d   = 2'd0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_d     = LOAD;
              seg_d       = 2'd0;
              remaining_d = repeat_val;
            end
          end
          LOAD: begin
            cnt_load       = 1'b1;
            cnt_load_value = start_val[seg_q[SEG_W-1:0]];
            state_d        = RUN;
          end
          RUN: begin
            // The counter parks on END for the final RUN cycle
            cnt_en = !at_end;
            if (at_end) state_d = NEXT;
          end
          NEXT: begin
            if (seg_q < last_seg) begin
              seg_d   = seg_q + 2'd1;
              state_d = LOAD;
            end else if (repeat_val == CNT_W'(REPEAT_INFINITE)) begin
              seg_d   = 2'd0;
              state_d = LOAD;
            end else if (remaining_q == CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              remaining_d = remaining_q - CNT_W'(1);
              seg_d       = 2'd0;
              state_d     = LOAD;
            end
          end
          DONE: begin
            done    = 1'b1;
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
            seg_d   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seg_q       <= 2'd0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      remaining_q <= remaining_d;
    end
  end

  assign seg_idx = seg_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       start;
  logic       abort;
  logic [7:0] cnt_q;
  logic       cnt_load;
  logic [7:0] cnt_load_value;
  logic       cnt_en;
  logic       cnt_oe;
  logic       busy;
  logic [1:0] seg_idx;
  logic       done;

  int checks = 0;
  int failures = 0;
  int done_total = 0;

  always #5 clk = ~clk;

  counter_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .start          (start),
    .abort          (abort),
    .cnt_value      (cnt_q),
    .cnt_load       (cnt_load),
    .cnt_load_value (cnt_load_value),
    .cnt_en         (cnt_en),
    .cnt_oe         (cnt_oe),
    .busy           (busy),
    .seg_idx        (seg_idx),
    .done           (done)
  );

  // Counter datapath model: load beats enable, wraps modulo 256
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_q <= 8'd0;
    else if (cnt_load) cnt_q <= cnt_load_value;
    else if (cnt_en)   cnt_q <= cnt_q + 8'd1;
  end

  always @(negedge clk) begin
    if (done) done_total <= done_total + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load"}, 32'(cnt_load), 32'd0);
    chk({tag, "_lval"}, 32'(cnt_load_value), 32'd0);
    chk({tag, "_en"},   32'(cnt_en), 32'd0);
    chk({tag, "_oe"},   32'(cnt_oe), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_seg"},  32'(seg_idx), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  logic [7:0] wrap_exp [4];
  logic [1:0] segs [4];
  int nload;
  int ndone;
  int done_at;
  int done_snap;

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 8'd0;
    start = 1'b0; abort = 1'b0;
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
    #3;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single segment 3 -> 7
    wr(4'd0, 8'd3); wr(4'd4, 8'd7); wr(4'd8, 8'd0); wr(4'd9, 8'd1);
    start = 1'b1;
    #1;
    chk("s_idle_busy", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    chk("s_c1_load", 32'(cnt_load), 32'd1);
    chk("s_c1_lval", 32'(cnt_load_value), 32'd3);
    chk("s_c1_busy", 32'(busy), 32'd1);
    chk("s_c1_oe", 32'(cnt_oe), 32'd0);
    step();
    for (int c = 2; c <= 6; c++) begin
      chk("s_run_cnt", 32'(cnt_q), 32'(c + 1));
      chk("s_run_en", 32'(cnt_en), 32'(c < 6));
      chk("s_run_oe", 32'(cnt_oe), 32'd1);
      step();
    end
    chk("s_c7_en", 32'(cnt_en), 32'd0);
    chk("s_c7_oe", 32'(cnt_oe), 32'd1);
    chk("s_c7_done", 32'(done), 32'd0);
    step();
    chk("s_c8_done", 32'(done), 32'd1);
    chk("s_c8_cnt", 32'(cnt_q), 32'd7);
    step();
    chk("s_c9_done", 32'(done), 32'd0);
    chk("s_c9_busy", 32'(busy), 32'd0);
    chk("s_c9_cnt", 32'(cnt_q), 32'd7);
    chk("s_c9_oe", 32'(cnt_oe), 32'd0);

    // Wrap FE -> 01
    wr(4'd0, 8'hFE); wr(4'd4, 8'h01);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("w_lval", 32'(cnt_load_value), 32'hFE);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("w_run_cnt", 32'(cnt_q), 32'(wrap_exp[i]));
      chk("w_run_en", 32'(cnt_en), 32'(i < 3));
      step();
    end
    chk("w_next_en", 32'(cnt_en), 32'd0);
    chk("w_next_oe", 32'(cnt_oe), 32'd1);
    step();
    chk("w_done", 32'(done), 32'd1);
    step();

    // Two segments, two passes
    wr(4'd0, 8'd10); wr(4'd1, 8'd20); wr(4'd4, 8'd12); wr(4'd5, 8'd20);
    wr(4'd8, 8'd1); wr(4'd9, 8'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    nload = 0; ndone = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (cnt_load) begin
        if (nload < 4) segs[nload] = seg_idx;
        nload++;
      end
      if (done) begin
        ndone++;
        done_at = c;
      end
      step();
    end
    chk("m_nload", 32'(nload), 32'd4);
    chk("m_seg0", 32'(segs[0]), 32'd0);
    chk("m_seg1", 32'(segs[1]), 32'd1);
    chk("m_seg2", 32'(segs[2]), 32'd0);
    chk("m_seg3", 32'(segs[3]), 32'd1);
    chk("m_ndone", 32'(ndone), 32'd1);
    chk("m_done_at", 32'(done_at), 32'd17);
    chk("m_busy_end", 32'(busy), 32'd0);

    // Infinite repeat, config lockout, abort
    wr(4'd9, 8'd0);
    done_snap = done_total;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_wdata = 8'h50;
    step();
    cfg_we = 1'b0;
    chk("a_cnt", 32'(cnt_q), 32'd11);
    chk("a_en_pre", 32'(cnt_en), 32'd1);
    abort = 1'b1;
    #1;
    chk("a_en_abort", 32'(cnt_en), 32'd0);
    step();
    abort = 1'b0;
    chk("a_busy", 32'(busy), 32'd0);
    chk("a_oe", 32'(cnt_oe), 32'd0);
    chk("a_seg", 32'(seg_idx), 32'd0);
    chk("a_cnt_hold", 32'(cnt_q), 32'd11);
    for (int k = 0; k < 5; k++) step();
    chk("a_idle", 32'(busy), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("l_lval", 32'(cnt_load_value), 32'd10);
    step(); step(); step();
    chk("l_end_cnt", 32'(cnt_q), 32'd12);
    chk("l_end_en", 32'(cnt_en), 32'd0);
    step(); step(); step();
    chk("l_seg1", 32'(seg_idx), 32'd1);
    chk("l_seg1_cnt", 32'(cnt_q), 32'd20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("l_abort_seg", 32'(seg_idx), 32'd0);
    chk("l_abort_busy", 32'(busy), 32'd0);
    step();
    chk("a_no_done", 32'(done_total), 32'(done_snap));

    // ena frozen for three cycles mid-RUN
    wr(4'd0, 8'd3); wr(4'd4, 8'd7); wr(4'd8, 8'd0); wr(4'd9, 8'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("e_cnt_pre", 32'(cnt_q), 32'd4);
    ena = 1'b0;
    #1;
    chk("e_en_off", 32'(cnt_en), 32'd0);
    chk("e_oe_hold", 32'(cnt_oe), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("e_frozen_cnt", 32'(cnt_q), 32'd4);
      chk("e_frozen_busy", 32'(busy), 32'd1);
      chk("e_frozen_done", 32'(done), 32'd0);
    end
    ena = 1'b1;
    #1;
    chk("e_en_resume", 32'(cnt_en), 32'd1);
    done_at = 0;
    for (int c = 6; c <= 13; c++) begin
      if (done) done_at = c;
      step();
    end
    chk("e_done_at", 32'(done_at), 32'd11);
    chk("e_cnt_final", 32'(cnt_q), 32'd7);

    // Asynchronous reset mid-RUN, then defaults
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("d_load", 32'(cnt_load), 32'd1);
    chk("d_lval", 32'(cnt_load_value), 32'd0);
    step();
    chk("d_cnt", 32'(cnt_q), 32'd0);
    chk("d_en", 32'(cnt_en), 32'd0);
    step();
    step();
    chk("d_done", 32'(done), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
